// File: rtl/prog_clk_div.sv
// prog_clk_div: programmable integer clock divider with sync restart.
// Emits a one-cycle tick and a near-50% divided clock every N cycles.
module prog_clk_div #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] div_ratio,
    input  logic         sync,
    output logic         tick,
    output logic         div_clk,
    output logic [W-1:0] active_ratio,
    output logic         running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] ratio_d;
    logic         tick_d;
    logic         dclk_d;
    logic         ratio_zero;
    logic         reload;

    assign ratio_zero = (div_ratio == '0);
    assign reload     = sync || (cnt_q == '0);
    assign running    = (state_q == RUN);

    // State and datapath registers; every output comes straight from here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tick         <= 1'b0;
            div_clk      <= 1'b0;
            active_ratio <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tick         <= tick_d;
            div_clk      <= dclk_d;
            active_ratio <= ratio_d;
        end
    end

    // Next state: a zero ratio seen at any reload point drops back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en && !ratio_zero) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (reload && ratio_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; ratio is only re-sampled at period boundaries.
    always_comb begin
        cnt_d   = '0;
        tick_d  = 1'b0;
        ratio_d = active_ratio;
        unique case (state_q)
            IDLE: begin
                ratio_d = div_ratio;
                if (en && !ratio_zero) begin
                    cnt_d = div_ratio - 1'b1;
                end
            end
            RUN: begin
                if (en) begin
                    if (reload) begin
                        ratio_d = div_ratio;
                        if (!ratio_zero) begin
                            cnt_d  = div_ratio - 1'b1;
                            tick_d = !sync;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        dclk_d = (state_d == RUN) && (cnt_d >= (ratio_d >> 1));
    end

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 The block SHALL have parameter W, default 8, setting the divide-ratio width; legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit: divider enable; 0 halts, 1 runs.
REQ-005 The block SHALL have port div_ratio, input, W bits: requested divide ratio N, unsigned; 0 means halt.
REQ-006 The block SHALL have port sync, input, 1 bit: phase restart request, one-cycle strobe.
REQ-007 The block SHALL have port tick, output, 1 bit: registered one-cycle pulse, once per N clk cycles.
REQ-008 The block SHALL have port div_clk, output, 1 bit: registered divided clock, high ceil(N/2) cycles of every N.
REQ-009 The block SHALL have port active_ratio, output, W bits: ratio currently in effect.
REQ-010 The block SHALL have port running, output, 1 bit: 1 while the FSM is in RUN.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-012 The block SHALL hold a W-bit down-counter cnt; in RUN it counts N-1 down to 0, then reloads N-1.
REQ-013 In IDLE, the block SHALL, every cycle, copy div_ratio into active_ratio, hold cnt=0, and drive tick=0 and div_clk=0.
REQ-014 The block SHALL move IDLE->RUN on an edge sampling en=1 and div_ratio!=0; on that edge cnt<=div_ratio-1, active_ratio<=div_ratio, and tick<=0.
REQ-015 The block SHALL move RUN->IDLE on any edge sampling en=0; on that same edge cnt, tick and div_clk SHALL go to 0 (no completion of the current period).
REQ-016 In RUN with cnt!=0 and sync=0, the block SHALL decrement cnt and drive tick<=0.
REQ-017 In RUN with cnt==0 and sync=0, the block SHALL drive tick<=1, sample div_ratio into active_ratio, and reload cnt<=div_ratio-1.
REQ-018 If the REQ-017 reload samples div_ratio==0, the block SHALL instead go to IDLE with tick<=0.
REQ-019 Changes to div_ratio while cnt!=0 in RUN SHALL NOT affect the current period; they take effect only at the next reload, giving a glitch-free ratio change.
REQ-020 In RUN with sync=1, the block SHALL reload cnt<=div_ratio-1, drive active_ratio<=div_ratio and tick<=0, regardless of cnt.
REQ-021 Sync SHALL take priority over the terminal count; if div_ratio==0, the sync edge goes to IDLE.
REQ-022 The block SHALL ignore sync in IDLE.
REQ-023 In RUN, div_clk SHALL be registered as div_clk <= (cnt_next >= (R>>1)), where cnt_next is the value loaded into cnt on the same edge and R is the ratio in effect after that edge.
REQ-024 Tick SHALL rise on the same edge as div_clk rises at each reload.
REQ-025 For N=1, tick and div_clk SHALL both be constantly 1 in RUN, starting from the edge after entry into RUN (div_clk is already 1 at entry).
REQ-026 In steady RUN, the first tick SHALL occur N edges after the IDLE->RUN edge, and subsequent ticks SHALL occur exactly every N cycles.
REQ-027 Subtraction div_ratio-1 SHALL be W-bit; the 0 case is excluded by REQ-018 and REQ-021, so no underflow reaches cnt.
REQ-028 The block SHALL contain no combinational path from clk or any input to any output; all outputs come from flops.

Reset
REQ-029 On an edge sampling reset=0, the block SHALL enter IDLE with cnt=0, tick=0, div_clk=0, active_ratio=0 and running=0, overriding en and sync.
REQ-030 Reset asserted mid-period SHALL abort that period with no tick.
REQ-031 After reset deasserts, the block SHALL restart per REQ-014.

Verification
REQ-032 Bench SHALL cover basic divide: N=5, en=1 held -> tick every 5 cycles, first on 5th edge after entry; div_clk 3 high / 2 low; running=1.
REQ-033 Bench SHALL cover ratio change: N=4 running, div_ratio->6 at cnt=2 -> current period still 4 cycles; next period 6 cycles with div_clk 3/3; active_ratio changes at the tick edge.
REQ-034 Bench SHALL cover sync: N=8, sync pulse at cnt=3 -> no tick at the expected slot; next tick 8 edges after the sync edge; sync coincident with cnt=0 -> no tick.
REQ-035 Bench SHALL cover boundaries: N=1 -> tick=div_clk=1 continuously; N=2 -> div_clk toggles 50%; div_ratio=0 at reload -> IDLE, outputs 0; div_ratio back to 3 -> restart per REQ-014.
REQ-036 Bench SHALL cover stop/reset: en dropped mid-period -> next edge tick=div_clk=0, running=0; reset=0 during RUN with N=7 -> all outputs 0 on that edge; recovery after reset=1 with first tick 7 edges after restart.
REQ-037 Bench SHALL cover W=4, N=15 -> tick period 15, div_clk 8 high / 7 low, no counter overflow.
